// File: rtl/diffeq_out_capture.sv
// Output capture stage for the difference-equation core: decimates strobed samples of y,
// buffers them in a small FIFO and hands them to a consumer over valid/ready.
module diffeq_out_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DECIM  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        y,
    input  logic                     sample_en,
    input  logic                     clear,
    output logic [DATA_W-1:0]        dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [LW-1:0]     level_reg, level_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              overflow_reg, overflow_next;
    logic [CW-1:0]     decim_cnt_reg, decim_cnt_next;

    logic keep, pop, push, full, drop;
    logic [AW-1:0] rd_ptr_inc;

    assign keep       = sample_en && (decim_cnt_reg == '0);
    assign pop        = (level_reg != '0) && out_ready;
    assign full       = (level_reg == LW'(DEPTH));
    assign push       = keep && (!full || pop);
    assign drop       = keep && full && !pop;
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        level_next     = level_reg;
        dout_next      = dout_reg;
        overflow_next  = overflow_reg;
        decim_cnt_next = decim_cnt_reg;

        if (clear) begin
            rd_ptr_next    = '0;
            wr_ptr_next    = '0;
            level_next     = '0;
            dout_next      = '0;
            overflow_next  = 1'b0;
            decim_cnt_next = '0;
        end else begin
            if (sample_en) begin
                if (DECIM == 1 || decim_cnt_reg == CW'(DECIM - 1))
                    decim_cnt_next = '0;
                else
                    decim_cnt_next = decim_cnt_reg + CW'(1);
            end

            if (pop)
                rd_ptr_next = rd_ptr_inc;
            if (push)
                wr_ptr_next = wr_ptr_reg + AW'(1);

            case ({push, pop})
                2'b10:   level_next = level_reg + LW'(1);
                2'b01:   level_next = level_reg - LW'(1);
                default: level_next = level_reg;
            endcase

            if (drop)
                overflow_next = 1'b1;

            // dout is a register tracking the next head: the entry after the current one
            // on a pop, or the incoming sample when it lands in an empty (or emptying) FIFO.
            if (level_next == '0)
                dout_next = '0;
            else if (pop)
                dout_next = (level_reg > LW'(1)) ? mem[rd_ptr_inc] : y;
            else if (level_reg == '0)
                dout_next = y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            level_reg     <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            decim_cnt_reg <= '0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            level_reg     <= level_next;
            dout_reg      <= dout_next;
            overflow_reg  <= overflow_next;
            decim_cnt_reg <= decim_cnt_next;
        end
    end

    // Storage carries no reset; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr_reg] <= y;
    end

    assign dout      = dout_reg;
    assign out_valid = (level_reg != '0);
    assign level     = level_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_diffeq_out_capture.sv
// Scoreboard bench: two instances (DECIM=1 and DECIM=3) share stimulus; a queue-based
// reference model predicts FIFO contents and a negedge monitor compares every cycle.
module tb_diffeq_out_capture;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] y = '0;
    logic       sample_en = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] dout_w     [2];
    logic       valid_w    [2];
    logic [3:0] level_w    [2];
    logic       overflow_w [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned exp_q [2][$];
    int          cnt   [2];
    bit          ovf   [2];
    int          decim [2] = '{1, 3};

    always #5 clk = ~clk;

    diffeq_out_capture #(.DATA_W(8), .DEPTH(DEPTH), .DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .y(y), .sample_en(sample_en), .clear(clear),
        .dout(dout_w[0]), .out_valid(valid_w[0]), .out_ready(out_ready),
        .level(level_w[0]), .overflow(overflow_w[0])
    );

    diffeq_out_capture #(.DATA_W(8), .DEPTH(DEPTH), .DECIM(3)) dut3 (
        .clk(clk), .reset(reset), .y(y), .sample_en(sample_en), .clear(clear),
        .dout(dout_w[1]), .out_valid(valid_w[1]), .out_ready(out_ready),
        .level(level_w[1]), .overflow(overflow_w[1])
    );

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: FIFO as a plain queue, decimation as a strobe count modulo DECIM.
    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset || clear) begin
                exp_q[k].delete();
                cnt[k] = 0;
                ovf[k] = 1'b0;
            end else begin
                bit do_pop, kept;
                do_pop = (exp_q[k].size() > 0) && out_ready;
                kept   = sample_en && (cnt[k] == 0);
                if (sample_en) cnt[k] = (cnt[k] + 1) % decim[k];
                if (do_pop) void'(exp_q[k].pop_front());
                if (kept) begin
                    if (exp_q[k].size() < DEPTH) exp_q[k].push_back(int'(y));
                    else ovf[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                int exp_head;
                exp_head = (exp_q[k].size() > 0) ? int'(exp_q[k][0]) : 0;
                check("out_valid", k, int'(valid_w[k]), int'(exp_q[k].size() > 0));
                check("level", k, int'(level_w[k]), exp_q[k].size());
                check("overflow", k, int'(overflow_w[k]), int'(ovf[k]));
                check("dout", k, int'(dout_w[k]), exp_head);
                if (valid_w[k] && out_ready)
                    $display("dut%0d accept dout=%02h level=%0d ovf=%0d", k, dout_w[k], level_w[k], overflow_w[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        y = 8'(v);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(2);
        for (int k = 0; k < 2; k++) begin
            check("rst_level", k, int'(level_w[k]), 0);
            check("rst_valid", k, int'(valid_w[k]), 0);
            check("rst_dout", k, int'(dout_w[k]), 0);
            check("rst_ovf", k, int'(overflow_w[k]), 0);
        end
        reset = 1'b1;
        tick();

        // Streaming with consumer always ready
        out_ready = 1'b1;
        strobe(1); strobe(3); strobe(6); strobe(10);
        idle(3);

        // Fill past capacity, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) strobe(i);
        check("ovf_after_fill", 0, int'(overflow_w[0]), 1);
        check("level_full", 0, int'(level_w[0]), 8);
        out_ready = 1'b1;
        idle(10);
        check("ovf_sticky", 0, int'(overflow_w[0]), 1);

        // Simultaneous push and pop at full
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) strobe(i);
        out_ready = 1'b1;
        strobe(8'h55);
        check("full_pushpop_level", 0, int'(level_w[0]), 8);
        check("full_pushpop_ovf", 0, int'(overflow_w[0]), 0);
        idle(10);

        // Decimation pattern
        do_clear();
        for (int i = 10; i <= 16; i++) strobe(i);
        idle(3);

        // Clear coincident with a strobe
        out_ready = 1'b0;
        for (int i = 20; i <= 30; i++) strobe(i);
        y = 8'h77; sample_en = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; sample_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("clr_level", k, int'(level_w[k]), 0);
            check("clr_ovf", k, int'(overflow_w[k]), 0);
        end
        strobe(8'h78);
        check("post_clear_kept", 1, int'(dout_w[1]), 8'h78);
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(8'h40 + i);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("async_level", k, int'(level_w[k]), 0);
            check("async_valid", k, int'(valid_w[k]), 0);
            check("async_dout", k, int'(dout_w[k]), 0);
        end
        idle(2);
        reset = 1'b1;
        tick();
        strobe(8'hA5);
        for (int k = 0; k < 2; k++) begin
            check("post_reset_dout", k, int'(dout_w[k]), 8'hA5);
            check("post_reset_valid", k, int'(valid_w[k]), 1);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            y         = 8'($urandom);
            sample_en = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            clear     = ($urandom_range(0, 99) < 2);
            tick();
        end
        sample_en = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
